// File: rtl/rikv_pkg.sv
// Shared definitions for the rikv core, its instruction buffer and the formal harness.
package rikv_pkg;

  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;

  // Default buffer geometry; pointers carry one extra wrap bit above the index.
  localparam int IBUF_DEPTH = 4;
  localparam int IBUF_PTRW  = $clog2(IBUF_DEPTH) + 1;

  typedef logic [IBUF_PTRW-1:0] ptr_t;

endpackage

// File: rtl/rikv_instr_buffer.sv
// Instruction prefetch FIFO between the fetch stream and the rikv core, with
// first-word fall-through and a single-cycle flush for branch/trap redirects.
module rikv_instr_buffer #(
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [ILEN-1:0]          in_instr,
  output logic                     in_ready,
  output logic                     instr_valid,
  output logic [ILEN-1:0]          instr,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);
  import rikv_pkg::*;

  localparam int AW   = $clog2(DEPTH);
  localparam int PTRW = AW + 1;

  logic [ILEN-1:0] mem [DEPTH];
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic            ready_q;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

  // ready_q keeps in_ready low through reset and for the release cycle.
  assign in_ready    = ready_q && !full && !flush;
  assign instr_valid = !empty && !flush;
  assign instr       = mem[rd_ptr[AW-1:0]];
  assign count       = wr_ptr - rd_ptr;

  assign push = in_valid && in_ready;
  assign pop  = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTRW'(1);
        if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      end
    end
  end

  // Storage is deliberately not reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_instr;
  end

`ifdef FORMAL
  logic past_ok;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) past_ok <= 1'b0;
    else          past_ok <= 1'b1;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      assert (32'(count) <= DEPTH);
      assert (!(full && empty));
      if (32'(count) == DEPTH) assert (!in_ready);
      if (past_ok && $past(instr_valid && !instr_ready && !flush))
        assert (instr == $past(instr));
    end
  end
`endif

endmodule

// File: tb/tb_rikv_instr_buffer.sv
// Directed bench for rikv_instr_buffer: stimulus queues expected words, a
// negedge monitor pops and compares them whenever the core side handshakes.
module tb_rikv_instr_buffer;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [ILEN-1:0] in_instr = '0;
  logic            in_ready;
  logic            instr_valid;
  logic [ILEN-1:0] instr;
  logic            instr_ready = 1'b0;
  logic [CW-1:0]   count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ILEN-1:0] exp_q [$];

  logic            prev_stall = 1'b0;
  logic [ILEN-1:0] prev_instr = '0;

  rikv_instr_buffer #(.ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one word that the bench expects the buffer to accept.
  task automatic push_word(input logic [ILEN-1:0] w);
    in_valid = 1'b1;
    in_instr = w;
    @(negedge clk);
    chk("push_in_ready", in_ready, 1);
    exp_q.push_back(w);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: compare every consumed word and hold-stability during stalls.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall) chk("hold_stable", instr, prev_instr);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", instr, $time);
        end else begin
          chk("out_word", instr, exp_q.pop_front());
        end
      end
    end
    prev_stall = reset_n && instr_valid && !instr_ready && !flush;
    prev_instr = instr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ILEN-1:0] words [4];
    int m_cnt;
    int sent;
    logic acc;
    logic pp;

    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    words[2] = 32'h0020_0113;
    words[3] = 32'h0030_0193;

    // 1. reset then idle
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_count", count, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_instr_valid", instr_valid, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_count", count, 0);
    end
    tick();

    // 2. fill with the core stalled, then drain in order
    for (int i = 0; i < 4; i++) push_word(words[i]);
    @(negedge clk);
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_instr_valid", instr_valid, 1);
    tick();
    instr_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("drain_instr_valid", instr_valid, 0);
    chk("drain_count", count, 0);
    chk("drain_queue", exp_q.size(), 0);
    tick();

    // 3. full buffer with push and pop offered together
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + 32'(i));
    in_valid = 1'b1;
    in_instr = 32'hB000_0000;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    tick();
    @(negedge clk);
    chk("after_pop_count", count, 3);
    chk("after_pop_in_ready", in_ready, 1);
    exp_q.push_back(32'hB000_0000);
    tick();
    in_valid = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    chk("push_pop_count", count, 3);
    tick();

    // 4. flush with an incoming word
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hC000_0000;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_instr_valid", instr_valid, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    instr_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_flush_count", count, 0);
    chk("post_flush_instr_valid", instr_valid, 0);
    tick();
    push_word(32'hD000_0000);
    @(negedge clk);
    chk("new_head_valid", instr_valid, 1);
    chk("new_head_count", count, 1);
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("new_head_drained", count, 0);
    tick();

    // 5. wrap-around stream with random consumer stalls
    m_cnt = 0;
    sent = 0;
    for (int cyc = 0; cyc < 300 && !(sent == 10 && m_cnt == 0); cyc++) begin
      in_valid = (sent < 10);
      in_instr = 32'h0000_0013 + (32'(sent) << 7);
      instr_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("stream_count", count, 64'(m_cnt));
      chk("stream_instr_valid", instr_valid, 64'(m_cnt > 0));
      chk("stream_in_ready", in_ready, 64'(m_cnt < DEPTH));
      acc = in_valid && (m_cnt < DEPTH);
      pp = (m_cnt > 0) && instr_ready;
      if (acc) begin
        exp_q.push_back(in_instr);
        sent++;
      end
      m_cnt = m_cnt + int'(acc) - int'(pp);
      tick();
    end
    in_valid = 1'b0;
    instr_ready = 1'b0;
    chk("stream_sent", sent, 10);
    chk("stream_model_empty", m_cnt, 0);
    @(negedge clk);
    chk("stream_queue", exp_q.size(), 0);
    tick();

    // 6. asynchronous reset in the middle of the stream
    push_word(32'hE000_0000);
    push_word(32'hE000_0001);
    @(negedge clk);
    chk("pre_reset_count", count, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_instr_valid", instr_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_in_ready", in_ready, 0);
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_count", count, 0);
    tick();
    push_word(32'hF000_0000);
    push_word(32'hF000_0001);
    @(negedge clk);
    chk("post_rst_fill", count, 2);
    tick();
    instr_ready = 1'b1;
    tick();
    tick();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("final_instr_valid", instr_valid, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
